// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 constants and the key-scheduling state type
//
// Used by the memory initializer, ksa_swap and the PRGA/decrypt stage.
//   DATA_WIDTH : S-box word and address width
//   ADDR_MAX   : last S-box index
//   KEY_BYTES  : key length in bytes
package rc4_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_MAX   = 255;
  localparam int KEY_BYTES  = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    GET_I,
    RD_J,
    GET_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/key_byte_sel.sv
// rtl/key_byte_sel.sv - selects key byte kidx, byte 0 being the most significant
//
// Ports:
//   key  : packed key, byte 0 = key[8*KEY_BYTES-1 -: 8]
//   kidx : byte index, 0 .. KEY_BYTES-1
//   kbyte: selected byte (0 for an out-of-range index)
module key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int KW        = 2
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KW-1:0]          kidx,
  output logic [7:0]             kbyte
);

  always_comb begin
    kbyte = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KW'(b)) begin
        kbyte = key[8*(KEY_BYTES-b)-1 -: 8];
      end
    end
  end

endmodule

// File: rtl/ksa_swap.sv
// rtl/ksa_swap.sv - RC4 key-scheduling pass over the S-box in single-port memory
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins the pass when sampled high in IDLE
//   key        : secret key, MSB-first bytes, stable from start to finish
//   address    : memory address
//   data       : memory write data
//   wren       : memory write enable
//   q          : memory read data, one cycle after address
//   finish     : sticky pass-complete flag
module ksa_swap
  import rc4_pkg::*;
#(
  parameter int DATA_WIDTH = rc4_pkg::DATA_WIDTH,
  parameter int ADDR_MAX   = rc4_pkg::ADDR_MAX,
  parameter int KEY_BYTES  = rc4_pkg::KEY_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8*KEY_BYTES-1:0]  key,
  output logic [DATA_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    wren,
  input  logic [DATA_WIDTH-1:0]   q,
  output logic                    finish
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t            state;
  logic [DATA_WIDTH-1:0] i, j, si, sj;
  logic [KW-1:0]         kidx;
  logic [7:0]            kbyte;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KW        (KW)
  ) u_key_byte_sel (
    .key   (key),
    .kidx  (kidx),
    .kbyte (kbyte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            state <= RD_I;
          end
        end
        RD_I:  state <= GET_I;
        GET_I: begin
          si    <= q;
          // 8-bit wraparound is the RC4 "mod 256"
          j     <= j + q + DATA_WIDTH'(kbyte);
          state <= RD_J;
        end
        RD_J:  state <= GET_J;
        GET_J: begin
          sj    <= q;
          state <= WR_I;
        end
        WR_I:  state <= WR_J;
        WR_J: begin
          if (i == DATA_WIDTH'(ADDR_MAX)) begin
            state <= DONE;
          end else begin
            i     <= i + 1'b1;
            kidx  <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + 1'b1;
            state <= RD_I;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and datapath registers only, so reset clears
  // them without waiting for a clock edge.
  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    finish  = 1'b0;
    case (state)
      RD_I, GET_I: address = i;
      RD_J, GET_J: address = j;
      WR_I: begin
        address = i;
        data    = sj;
        wren    = 1'b1;
      end
      WR_J: begin
        address = j;
        data    = si;
        wren    = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: address = '0;
    endcase
  end

endmodule

// File: tb/tb_ksa_swap.sv
// tb/tb_ksa_swap.sv - self-checking bench for ksa_swap
module tb_ksa_swap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] key;
  logic [7:0]  address, data, q;
  logic        wren, finish;
  logic        do_init;
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  ksa_swap dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key     (key),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .finish  (finish)
  );

  // single-port memory with one-cycle read latency; do_init plays the initializer
  always @(posedge clk) begin
    q <= mem[address];
    if (do_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[address] <= data;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reference: plain software RC4 KSA plus the write sequence it implies
  int exp_s  [256];
  int exp_wa [512];
  int exp_wd [512];

  function automatic void ksa_model(input logic [23:0] k);
    int s [256];
    int jj, kb, t;
    for (int n = 0; n < 256; n++) s[n] = n;
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb = int'((k >> (8 * (2 - (n % 3)))) & 24'hff);
      jj = (jj + s[n] + kb) % 256;
      exp_wa[2*n]   = n;
      exp_wd[2*n]   = s[jj];
      exp_wa[2*n+1] = jj;
      exp_wd[2*n+1] = s[n];
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    for (int n = 0; n < 256; n++) exp_s[n] = s[n];
  endfunction

  typedef struct {
    logic [23:0] key;
    int          widx;
    int          addr;
    int          wdata;
  } vec_t;

  vec_t vecs [10];

  int lw_addr [512];
  int lw_data [512];
  int nwr, rise_e, slot_err, sticky_err;

  task automatic init_mem();
    @(negedge clk); do_init = 1'b1;
    @(negedge clk); do_init = 1'b0;
  endtask

  // edge 0 samples start; e counts edges after it, sampled on the falling edge
  task automatic run_pass(input logic [23:0] k, input bit hold, input bit rel);
    key = k;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    nwr = 0; rise_e = -1; slot_err = 0; sticky_err = 0;
    for (int e = 0; e < 1545; e++) begin
      if (wren) begin
        if (nwr < 512) begin
          lw_addr[nwr] = int'(address);
          lw_data[nwr] = int'(data);
        end
        nwr++;
        if (!(e < 1536 && (e % 6 == 4 || e % 6 == 5))) slot_err++;
      end
      if (finish && rise_e < 0) rise_e = e;
      if (!finish && rise_e >= 0) sticky_err++;
      @(negedge clk);
    end
  endtask

  task automatic check_pass(input string name);
    int wmis, mmis;
    wmis = 0; mmis = 0;
    check({name, "_finish_edge"}, rise_e, 1536);
    check({name, "_write_count"}, nwr, 512);
    check({name, "_write_slots"}, slot_err, 0);
    check({name, "_finish_sticky"}, sticky_err, 0);
    for (int n = 0; n < 512 && n < nwr; n++)
      if (lw_addr[n] != exp_wa[n] || lw_data[n] != exp_wd[n]) wmis++;
    check({name, "_write_seq_mismatches"}, wmis, 0);
    for (int n = 0; n < 256; n++)
      if (int'(mem[n]) != exp_s[n]) mmis++;
    check({name, "_sbox_mismatches"}, mmis, 0);
  endtask

  task automatic table_check(input logic [23:0] k);
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].key == k) begin
        check($sformatf("vec%0d_addr", v), lw_addr[vecs[v].widx], vecs[v].addr);
        check($sformatf("vec%0d_data", v), lw_data[vecs[v].widx], vecs[v].wdata);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_address"}, address, 0);
    check({name, "_data"}, data, 0);
    check({name, "_wren"}, wren, 0);
    check({name, "_finish"}, finish, 0);
  endtask

  initial begin
    int extra;
    logic [23:0] rk;

    // key 0: i=0,1 self-swaps, i=2 swaps with j=3
    vecs[0] = '{24'h000000, 0, 0, 0};
    vecs[1] = '{24'h000000, 1, 0, 0};
    vecs[2] = '{24'h000000, 2, 1, 1};
    vecs[3] = '{24'h000000, 3, 1, 1};
    vecs[4] = '{24'h000000, 4, 2, 3};
    vecs[5] = '{24'h000000, 5, 3, 2};
    // key 010203: i=0 swaps with j=1, i=1 swaps with j=3
    vecs[6] = '{24'h010203, 0, 0, 1};
    vecs[7] = '{24'h010203, 1, 1, 0};
    vecs[8] = '{24'h010203, 2, 1, 3};
    vecs[9] = '{24'h010203, 3, 3, 0};

    rst_n = 1'b0; start = 1'b0; key = '0; do_init = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");

    init_mem();
    ksa_model(24'h000000);
    run_pass(24'h000000, 1'b0, 1'b1);
    check_pass("key0");
    table_check(24'h000000);

    // start while DONE must not touch memory
    extra = 0;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wren) extra++;
    end
    start = 1'b0;
    check("done_restart_writes", extra, 0);
    check("done_restart_finish", finish, 1);

    rst_n = 1'b0;
    init_mem();
    ksa_model(24'h010203);
    run_pass(24'h010203, 1'b0, 1'b1);
    check_pass("key010203");
    table_check(24'h010203);

    for (int r = 0; r < 3; r++) begin
      rst_n = 1'b0;
      rk = 24'($urandom);
      init_mem();
      ksa_model(rk);
      run_pass(rk, 1'b0, 1'b1);
      check_pass($sformatf("rand%0d", r));
    end

    // abort mid-pass during a write cycle, then rerun from a fresh init
    rst_n = 1'b0;
    rk = 24'($urandom);
    init_mem();
    key = rk;
    @(negedge clk); rst_n = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (700) @(negedge clk);
    check("midpass_wren_before_reset", wren, 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midpass_async");
    init_mem();
    ksa_model(rk);
    run_pass(rk, 1'b0, 1'b1);
    check_pass("after_abort");

    // start held high from reset release: one pass only, finish sticky
    rst_n = 1'b0;
    rk = 24'($urandom);
    init_mem();
    ksa_model(rk);
    run_pass(rk, 1'b1, 1'b1);
    check_pass("held_start");
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ksa_swap.md
# ksa_swap

Runs the RC4 key-scheduling pass over the 256-byte S-box in on-chip memory, directly downstream of the memory initializer. After the initializer reports done (S[k] = k), this block is started. It walks i from 0 to ADDR_MAX and, for each i, computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] with S[j]. It uses the same single-port memory interface. Its finish flag hands the scrambled S-box to the PRGA/decrypt stage.

## Interface
- DATA_WIDTH, 8: memory word and address width (equal).
- ADDR_MAX, 255: last index processed.
- KEY_BYTES, 3: key length in bytes.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  sampled only in IDLE; a high sample begins the pass.
- key  in  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first); held stable from start to finish.
- address  out  DATA_WIDTH  memory address.
- data  out  DATA_WIDTH  memory write data.
- wren  out  1  memory write enable.
- q  in  DATA_WIDTH  memory read data; valid the cycle after address is presented (one-cycle read latency).
- finish  out  1  high when the pass is complete; sticky.

## Operation
- States: IDLE, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE.
- IDLE: address = 0, wren = 0. On start: i = 0, j = 0, kidx = 0, then go to RD_I.
- RD_I: address = i.
- GET_I: address = i. Register si <= q. Register j <= j + q + key byte[kidx] (mod 2^DATA_WIDTH; carries discarded).
- RD_J: address = j (the new j).
- GET_J: address = j. Register sj <= q.
- WR_I: address = i, data = sj, wren = 1.
- WR_J: address = j, data = si, wren = 1.
  - If i == ADDR_MAX, go to DONE.
  - Otherwise i <= i + 1, kidx <= (kidx == KEY_BYTES-1) ? 0 : kidx + 1, and go to RD_I.
- kidx is a wrap counter; no divider or modulo operator.
- DONE: finish = 1, wren = 0. Held until reset. start is ignored.
- start in any non-IDLE state is ignored.
- i == j: both writes store the same value; S is unchanged, which is correct.
- address, data, wren and finish decode only from registered state and datapath registers; no combinational path from q or start.

## Timing
- Reset (async assert): state = IDLE; i, j, si, sj, kidx = 0; address = 0, data = 0, wren = 0, finish = 0.
- Reset release is synchronous to clk.
- Reset mid-pass aborts at once. Memory is left partially swapped, and the initializer must be rerun before restarting.
- Each iteration takes 6 cycles, with exactly 2 write cycles (WR_I, WR_J).
- Edge 0 samples start. finish rises after edge 6*(ADDR_MAX+1), i.e. edge 1536 for defaults.
- At most one memory access per cycle; wren is never high in read states.

## Structure
- Shared package rc4_pkg:
  - state enum ksa_state_t.
  - constants KEY_BYTES, ADDR_MAX and DATA_WIDTH defaults, also used by the initializer and the PRGA.
- One natural sub-module, key_byte_sel: mux that selects byte kidx from key, MSB-first.
- FSM and datapath (i, j, si, sj, kidx) live in ksa_swap.

## Test plan
- Identity S-box, key 24'h000000:
  - i=0 and i=1 are self-swaps.
  - i=2 gives j=3, so S[2]=3 and S[3]=2.
  - Full 256-entry result matches the software RC4 KSA model.
- Identity S-box, key 24'h010203:
  - i=0 gives j=1, so S[0]=1 and S[1]=0.
  - i=1 gives j=3, so S[1]=3 and S[3]=0.
  - Final array matches the model.
- Latency and handshake:
  - start pulsed once; finish rises exactly 1536 cycles after the sampling edge and stays high.
  - A second start while in DONE produces no memory writes.
- Protocol check: every cycle, at most one of read/write; wren high only in WR_I/WR_J; exactly 512 write cycles per pass.
- Reset mid-pass:
  - rst_n low at cycle 700: outputs go to 0 immediately, without waiting for a clock edge.
  - After release, re-init plus start gives a correct full result.
- start held high continuously from reset release: exactly one pass runs; finish is sticky.
